// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and defaults for the mem_responder slice.
//   state_e            : responder FSM states (ST_ACC_HI only with MEM_RESP_WORD_EN)
//   MEM_RESP_DEPTH_DEF : default storage size in bytes
//   MEM_RESP_WAIT_DEF  : default number of wait states
// Optional feature macro: MEM_RESP_WORD_EN (16-bit little-endian accesses).
package mem_resp_pkg;

   localparam int unsigned MEM_RESP_DEPTH_DEF = 1024;
   localparam int unsigned MEM_RESP_WAIT_DEF  = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACC_LO,
`ifdef MEM_RESP_WORD_EN
      ST_ACC_HI,
`endif
      ST_RESP
   } state_e;

endpackage

// File: rtl/mem_resp_bank.sv
// mem_resp_bank: single-port DEPTH x 8 byte array.
//   clk_i   : clock, write happens on rising edge when we_i=1
//   we_i    : write enable
//   addr_i  : byte index
//   wdata_i : write byte
//   rdata_o : read byte at addr_i
// The write is synchronous; the read path is combinational so the
// responder can capture the byte on the same edge that leaves an access
// state, which keeps Ack and valid read data in the same cycle.
module mem_resp_bank #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte-addressed memory slave with Req/Ack handshake and
// a fixed number of wait states before the array access.
//   Clock, Reset : clock, synchronous active-high reset
//   Req          : request strobe, sampled only in IDLE
//   Wr           : 1 = write, 0 = read
//   Word         : 1 = 16-bit access (only with MEM_RESP_WORD_EN)
//   Address      : byte address, aliased modulo DEPTH
//   DataIn       : write data ([7:0] for byte writes)
//   Ack          : one-cycle completion pulse
//   Busy         : high while a request is in progress
//   DataOut      : last read data, held until the next read completes
// Optional feature macro: MEM_RESP_WORD_EN.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH       = MEM_RESP_DEPTH_DEF,
   parameter int unsigned WAIT_STATES = MEM_RESP_WAIT_DEF
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Req,
   input  logic        Wr,
`ifdef MEM_RESP_WORD_EN
   input  logic        Word,
`endif
   input  logic [15:0] Address,
   input  logic [15:0] DataIn,
   output logic        Ack,
   output logic        Busy,
   output logic [15:0] DataOut
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] dout_q, dout_d;
`ifdef MEM_RESP_WORD_EN
   logic        word_q, word_d;
`endif

   logic [15:0] acc_addr;
   logic        bank_we;
   logic [7:0]  bank_wdata;
   logic [7:0]  bank_rdata;

   // Array-side signals: high byte uses Address+1 with 16-bit wrap.
   // Reset gates the write so an access interrupted on this edge is dropped.
   always_comb begin
      acc_addr   = addr_q;
      bank_wdata = wdata_q[7:0];
      bank_we    = wr_q && !Reset && (state_q == ST_ACC_LO);
`ifdef MEM_RESP_WORD_EN
      if (state_q == ST_ACC_HI) begin
         acc_addr   = addr_q + 16'd1;
         bank_wdata = wdata_q[15:8];
         bank_we    = wr_q && !Reset;
      end
`endif
   end

   mem_resp_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_bank (
      .clk_i   (Clock),
      .we_i    (bank_we),
      .addr_i  (acc_addr[AW-1:0]),
      .wdata_i (bank_wdata),
      .rdata_o (bank_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
`ifdef MEM_RESP_WORD_EN
      word_d  = word_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (Req) begin
               wr_d    = Wr;
               addr_d  = Address;
               wdata_d = DataIn;
`ifdef MEM_RESP_WORD_EN
               word_d  = Word;
`endif
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACC_LO;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_ACC_LO;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACC_LO: begin
            if (!wr_q) begin
               dout_d[7:0]  = bank_rdata;
               dout_d[15:8] = '0;
            end
            state_d = ST_RESP;
`ifdef MEM_RESP_WORD_EN
            if (word_q) begin
               dout_d[15:8] = dout_q[15:8];
               state_d      = ST_ACC_HI;
            end
         end
         ST_ACC_HI: begin
            if (!wr_q) begin
               dout_d[15:8] = bank_rdata;
            end
            state_d = ST_RESP;
`endif
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
`ifdef MEM_RESP_WORD_EN
         word_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
`ifdef MEM_RESP_WORD_EN
         word_q  <= word_d;
`endif
      end
   end

   assign Ack     = (state_q == ST_RESP);
   assign Busy    = (state_q != ST_IDLE);
   assign DataOut = dout_q;

   // Bits above the array index (and the high write byte in byte-only
   // builds) are intentionally not consumed.
   logic unused_ok;
   assign unused_ok = ^{acc_addr, wdata_q};

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int unsigned D  = 1024;
   localparam int unsigned WS = 1;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Req;
   logic        Wr;
`ifdef MEM_RESP_WORD_EN
   logic        Word;
`endif
   logic [15:0] Address;
   logic [15:0] DataIn;
   logic        Ack;
   logic        Busy;
   logic [15:0] DataOut;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  ref_mem [D];
   logic [15:0] ref_dout;

   typedef struct {
      bit          wr;
      bit          word;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   mem_responder #(
      .DEPTH       (D),
      .WAIT_STATES (WS)
   ) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Req     (Req),
      .Wr      (Wr),
`ifdef MEM_RESP_WORD_EN
      .Word    (Word),
`endif
      .Address (Address),
      .DataIn  (DataIn),
      .Ack     (Ack),
      .Busy    (Busy),
      .DataOut (DataOut)
   );

   always #5 Clock = ~Clock;

   initial begin
      #5ms;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one request in the current IDLE cycle, wait for Ack, then step
   // one more edge so the responder is back in IDLE on return.
   task automatic access(input bit wr, input bit word, input logic [15:0] addr,
                         input logic [15:0] data, output logic [15:0] dout);
      int lat;
      lat = 0;
      Req = 1'b1; Wr = wr; Address = addr; DataIn = data;
`ifdef MEM_RESP_WORD_EN
      Word = word;
`endif
      for (int k = 1; k <= 64 && lat == 0; k++) begin
         @(posedge Clock); #1;
         Req = 1'b0;
         if (Ack) lat = k;
      end
      dout = DataOut;
      check("ack_latency", lat, WS + 2 + (word ? 1 : 0));
      @(posedge Clock); #1;
      check("ack_pulse_idle", {30'd0, Ack, Busy}, 32'd0);
   endtask

   task automatic run_op(input bit wr, input bit word, input logic [15:0] addr,
                         input logic [15:0] data, input string name);
      logic [15:0] got;
      int lo, hi;
      lo = int'(addr) % D;
      hi = ((int'(addr) + 1) % 65536) % D;
      if (wr) begin
         ref_mem[lo] = data[7:0];
         if (word) ref_mem[hi] = data[15:8];
      end else begin
         ref_dout = word ? {ref_mem[hi], ref_mem[lo]} : {8'h00, ref_mem[lo]};
      end
      access(wr, word, addr, data, got);
      check(name, got, ref_dout);
   endtask

   initial begin
      logic [15:0] got;
      int acks, lows, first, last, gap_err;
      bit          w;

      Reset = 1'b1; Req = 1'b0; Wr = 1'b0; Address = '0; DataIn = '0;
`ifdef MEM_RESP_WORD_EN
      Word = 1'b0;
`endif
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      check("reset_ack",  Ack, 0);
      check("reset_busy", Busy, 0);
      check("reset_dout", DataOut, 16'h0000);

      // Directed vectors; exp is the DataOut required after each access.
      vecs.push_back('{1, 0, 16'h0010, 16'h00A5, 16'h0000});
      vecs.push_back('{0, 0, 16'h0010, 16'h0000, 16'h00A5});
      vecs.push_back('{1, 0, 16'h0400, 16'h005A, 16'h00A5});
      vecs.push_back('{0, 0, 16'h0000, 16'h0000, 16'h005A});
      vecs.push_back('{0, 0, 16'h0400, 16'h0000, 16'h005A});
      vecs.push_back('{1, 0, 16'h03FF, 16'hFFC3, 16'h005A});
      vecs.push_back('{0, 0, 16'hFFFF, 16'h0000, 16'h00C3});
      vecs.push_back('{1, 0, 16'h0011, 16'h7711, 16'h00C3});
      vecs.push_back('{0, 0, 16'h0011, 16'h0000, 16'h0011});
`ifdef MEM_RESP_WORD_EN
      vecs.push_back('{1, 1, 16'h0020, 16'hBEEF, 16'h0011});
      vecs.push_back('{0, 0, 16'h0020, 16'h0000, 16'h00EF});
      vecs.push_back('{0, 0, 16'h0021, 16'h0000, 16'h00BE});
      vecs.push_back('{0, 1, 16'h0020, 16'h0000, 16'hBEEF});
      vecs.push_back('{1, 1, 16'hFFFF, 16'h1234, 16'hBEEF});
      vecs.push_back('{0, 0, 16'h03FF, 16'h0000, 16'h0034});
      vecs.push_back('{0, 0, 16'h0400, 16'h0000, 16'h0012});
      vecs.push_back('{0, 1, 16'hFFFF, 16'h0000, 16'h1234});
      vecs.push_back('{0, 0, 16'h0010, 16'h0000, 16'h00A5});
`endif
      foreach (vecs[i]) begin
         access(vecs[i].wr, vecs[i].word, vecs[i].addr, vecs[i].data, got);
         check($sformatf("vec%0d_dout", i), got, vecs[i].exp);
      end
      ref_dout = vecs[vecs.size() - 1].exp;

      // Reset wins over Req in the same cycle.
      Req = 1'b1; Wr = 1'b0; Address = 16'h0010; Reset = 1'b1;
      @(posedge Clock); #1;
      Req = 1'b0; Reset = 1'b0;
      check("rst_req_busy", Busy, 0);
      check("rst_req_dout", DataOut, 16'h0000);
      ref_dout = 16'h0000;
      acks = 0;
      repeat (WS + 4) begin
         @(posedge Clock); #1;
         if (Ack || Busy) acks++;
      end
      check("rst_req_quiet", acks, 0);

      // Fill the whole array so every later read has a known answer.
      for (int i = 0; i < int'(D); i++) begin
         run_op(1'b1, 1'b0, 16'(i), 16'($urandom), "init_dout");
      end

      // Randomised traffic against the byte-array model.
      for (int n = 0; n < 300; n++) begin
`ifdef MEM_RESP_WORD_EN
         w = 1'($urandom_range(0, 1));
`else
         w = 1'b0;
`endif
         run_op(1'($urandom_range(0, 1)), w, 16'($urandom), 16'($urandom), "rand_dout");
      end

      // Req held high: one byte read completes every WS+3 cycles.
      Req = 1'b1; Wr = 1'b0; Address = 16'h0123;
`ifdef MEM_RESP_WORD_EN
      Word = 1'b0;
`endif
      acks = 0; lows = 0; first = 0; last = 0; gap_err = 0;
      for (int c = 1; c <= 3 * int'(WS + 3); c++) begin
         @(posedge Clock); #1;
         if (Ack) begin
            if (acks == 0) first = c;
            else if (c - last != int'(WS + 3)) gap_err++;
            last = c;
            acks++;
         end
         if (!Busy) lows++;
      end
      Req = 1'b0;
      ref_dout = {8'h00, ref_mem[16'h0123 % D]};
      check("held_first_ack", first, WS + 2);
      check("held_ack_count", acks, 3);
      check("held_ack_gap",   gap_err, 0);
      check("held_busy_low",  lows, 3);
      check("held_dout",      DataOut, ref_dout);
      @(posedge Clock); #1;
      check("held_idle", {30'd0, Ack, Busy}, 32'd0);

      // Reset in the cycle after acceptance aborts a read.
      Req = 1'b1; Wr = 1'b0; Address = 16'h0200;
      @(posedge Clock); #1;
      Req = 1'b0;
      check("midrd_busy", Busy, 1);
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      check("midrd_idle", {30'd0, Ack, Busy}, 32'd0);
      check("midrd_dout", DataOut, 16'h0000);
      ref_dout = 16'h0000;
      acks = 0;
      repeat (WS + 4) begin
         @(posedge Clock); #1;
         if (Ack) acks++;
      end
      check("midrd_no_ack", acks, 0);

      // Reset before the array access leaves memory untouched.
      Req = 1'b1; Wr = 1'b1; Address = 16'h0155; DataIn = {8'h00, ~ref_mem[16'h0155]};
      @(posedge Clock); #1;
      Req = 1'b0;
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      check("midwr_idle", {30'd0, Ack, Busy}, 32'd0);
      run_op(1'b0, 1'b0, 16'h0155, 16'h0000, "midwr_mem");

`ifdef MEM_RESP_WORD_EN
      // Reset during the high-byte cycle: low byte committed, high byte not.
      Req = 1'b1; Wr = 1'b1; Word = 1'b1; Address = 16'h0030; DataIn = 16'hCAFE;
      for (int k = 1; k <= int'(WS + 2); k++) begin
         @(posedge Clock); #1;
         Req = 1'b0;
      end
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      check("acchi_idle", {30'd0, Ack, Busy}, 32'd0);
      acks = 0;
      repeat (4) begin
         @(posedge Clock); #1;
         if (Ack) acks++;
      end
      check("acchi_no_ack", acks, 0);
      ref_mem[16'h0030] = 8'hFE;
      ref_dout = 16'h0000;
      run_op(1'b0, 1'b0, 16'h0030, 16'h0000, "acchi_lo");
      run_op(1'b0, 1'b0, 16'h0031, 16'h0000, "acchi_hi");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-addressed memory responder sitting at the far end of the address path. It serves the 16-bit addresses that the address register file drives on OutC/OutD (PC fetch, AR data access, SP stack access). It accepts one request at a time through a Req/Ack handshake, inserts a fixed number of wait states, and performs byte or little-endian word reads and writes. This is the slave-side counterpart the CPU datapath's address sources talk to.

## Interface
- DEPTH, 1024 — bytes of storage; power of two, 2..65536
- WAIT_STATES, 1 — idle cycles between request acceptance and the first array access; 0..15
- Clock  in  1  — single clock; all state changes on rising edge
- Reset  in  1  — synchronous, active-high
- Req  in  1  — request strobe, sampled only in IDLE
- Wr  in  1  — 1 = write, 0 = read; sampled with Req
- Word  in  1  — 1 = 16-bit access, 0 = byte; present only with MEM_RESP_WORD_EN
- Address  in  16  — byte address; sampled with Req
- DataIn  in  16  — write data; [7:0] for byte writes; sampled with Req
- Ack  out  1  — one-cycle completion pulse
- Busy  out  1  — high whenever a request is in progress (state != IDLE)
- DataOut  out  16  — read data; holds its value until the next read completes

## Operation
- States: IDLE, WAIT, ACC_LO, ACC_HI (word only), RESP.
- IDLE: if Req=1, latch Wr, Word, Address, DataIn; go to WAIT (or to ACC_LO if WAIT_STATES=0). Req=0 stays in IDLE.
- WAIT: count down WAIT_STATES cycles, then go to ACC_LO.
- ACC_LO: index = Address mod DEPTH. Write: mem[index] <= DataIn[7:0]. Read: DataOut[7:0] <= mem[index]; for a byte read, DataOut[15:8] <= 8'h00. Next state is ACC_HI for a word access, else RESP.
- ACC_HI: address = Address + 1 (16-bit wrap, 16'hFFFF -> 16'h0000), then mod DEPTH. Write: DataIn[15:8]. Read: DataOut[15:8]. Next state is RESP.
- RESP: Ack=1 for this cycle only; next state is IDLE.
- Writes never change DataOut.
- Req is ignored outside IDLE. A request held high through RESP is re-sampled in IDLE and starts a new access.
- Addresses at or above DEPTH alias modulo DEPTH. No error is flagged.

## Timing
- Reset values: state=IDLE, Ack=0, Busy=0, DataOut=16'h0000, wait counter=0. Memory contents are not reset.
- Req sampled at edge N. Byte access: Ack is high in the cycle starting at edge N+WAIT_STATES+2. Word access: edge N+WAIT_STATES+3.
- Busy rises at edge N+1 and falls at the edge where Ack falls.
- Back-to-back throughput: one access per WAIT_STATES+3 cycles (byte), because IDLE costs one cycle.
- Read data is valid on DataOut in the same cycle that Ack is high.
- Reset mid-operation: returns to IDLE next edge and discards the request. An ACC_LO write already committed persists. A pending ACC_HI write is not performed.
- Reset takes priority over Req in the same cycle.

## Configuration
- MEM_RESP_WORD_EN defined: Word port, ACC_HI state and 16-bit accesses exist.
- MEM_RESP_WORD_EN undefined: no Word port and no ACC_HI state. Every access is a byte access: reads zero-extend, writes use DataIn[7:0].

## Structure
- mem_resp_pkg: state enum (IDLE, WAIT, ACC_LO, ACC_HI, RESP); default DEPTH and WAIT_STATES constants.
- Sub-module mem_resp_bank: single-port DEPTH x 8 synchronous array (we, addr, wdata, rdata). The responder FSM drives it.

## Test plan
- Reset, then idle -> Ack=0, Busy=0, DataOut=16'h0000.
- WAIT_STATES=1: byte write 8'hA5 to 16'h0010 at edge 0, then byte read of 16'h0010 -> Ack at edge 3 and at edge 7, DataOut=16'h00A5.
- Word write 16'hBEEF to 16'h0020, then byte reads of 16'h0020 and 16'h0021 -> 16'h00EF and 16'h00BE. A word read of 16'h0020 returns 16'hBEEF.
- DEPTH=1024: word write 16'h1234 to 16'hFFFF -> mem[1023]=8'h34, mem[0]=8'h12. A byte read of 16'h0400 returns mem[0].
- Req held high continuously -> exactly one Ack per WAIT_STATES+3 (byte) cycles. No request is dropped or duplicated, and Busy is low for exactly one cycle between accesses.
- Word write 16'hCAFE to 16'h0030 with Reset asserted during ACC_HI -> mem[0x30]=8'hFE, mem[0x31] unchanged, no Ack, state IDLE.
